mem_bus_responder: RTL

Memory-side agent for the CPU core's 8-bit byte-serial bus. It holds instruction and data word arrays. It captures 16-bit word addresses and store data from `out_bus`, and returns instruction or load words on `in_bus`. It is the synthesizable counterpart of the core's bus initiator and sits between `cpu_core` and the board-level memory, in place of the Arduino-side model.

---
 rtl/mem_bus_responder.sv | 284 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_bus_responder.sv
// -----------------------------------------------------------------------------
// mem_bus_responder
//
// Memory-side agent for the core's 8-bit byte-serial bus. It holds an
// instruction array and a data array of DEPTH 16-bit words each. It captures
// little-endian word addresses and store data from out_bus. It returns
// instruction words (one or two) or load words on in_bus, low byte first.
//
// Build option:
//   MEM_BUS_RESPONDER_UNIFIED_EN - when defined, one DEPTH-word array serves
//   fetch, load, store, the host port and the debug read. That array is not
//   cleared by rst. When undefined, the instruction and data arrays are
//   separate, and rst clears only the data array.
//
// Ports:
//   clk               - single clock, rising edge
//   rst               - synchronous reset, active high
//   out_bus[7:0]      - byte from the core (address or store data)
//   bus_pc            - core requests an instruction fetch
//   bus_mar           - core requests a data access
//   bus_mdr           - qualifies bus_mar: 1 = store, 0 = load
//   halt              - core has executed SYS_END
//   in_bus[7:0]       - byte to the core, 0 when ard_data_ready is low
//   ard_data_ready    - in_bus holds a valid byte this cycle
//   ard_receive_ready - a new request is accepted this cycle
//   prog_we           - host write strobe (instruction array)
//   prog_addr[AW-1:0] - host write word address
//   prog_data[15:0]   - host write data
//   dbg_addr[AW-1:0]  - debug read address
//   dbg_data[15:0]    - combinational read of the data array at dbg_addr
// -----------------------------------------------------------------------------

package mem_bus_responder_pkg;
    // Instruction-format codes in the low nibble of an instruction word.
    // An instruction of either format carries a second word (W1).
    localparam logic [3:0] I_TYPE = 4'h1;
    localparam logic [3:0] M_TYPE = 4'h2;
endpackage

module mem_bus_responder
    import mem_bus_responder_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    out_bus,
    input  logic          bus_pc,
    input  logic          bus_mar,
    input  logic          bus_mdr,
    input  logic          halt,
    output logic [7:0]    in_bus,
    output logic          ard_data_ready,
    output logic          ard_receive_ready,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [15:0]   prog_data,
    input  logic [AW-1:0] dbg_addr,
    output logic [15:0]   dbg_data
);

    typedef enum logic [3:0] {
        IDLE,
        ADDR_HI,
        TX0_LO,
        TX0_HI,
        TX1_LO,
        TX1_HI,
        ST_LO,
        ST_HI,
        HALTED
    } state_e;

    typedef enum logic [1:0] {
        REQ_FETCH,
        REQ_LOAD,
        REQ_STORE
    } req_e;

    state_e        state_q, state_d;
    req_e          kind_q;
    logic [AW-1:0] idx_q;       // word index; upper address bits are dropped
    logic [AW-1:0] idx_full;    // index including the address high byte
    logic [AW-1:0] idx_next;    // following word, wraps modulo DEPTH
    logic [15:0]   w0_q, w1_q;  // words being transmitted
    logic [7:0]    st_lo_q;     // low byte of pending store data
    logic [15:0]   instr_rd;    // instr[idx_full]
    logic [15:0]   instr_nxt;   // instr[idx_next]
    logic [15:0]   data_rd;     // data[idx_full]
    logic          req_valid;
    logic          store_commit;
    logic          long_instr;

    // ------------------------------------------------------------------
    // Index assembly. The address low byte is latched in IDLE. The high
    // byte is still on out_bus during ADDR_HI, and it only matters when
    // the arrays are deeper than 256 words.
    // ------------------------------------------------------------------
    generate
        if (AW > 8) begin : g_wide_idx
            assign idx_full = AW'({out_bus, idx_q[7:0]});
        end else begin : g_narrow_idx
            assign idx_full = idx_q;
        end
    endgenerate

    assign idx_next     = idx_full + AW'(1);
    assign req_valid    = bus_pc || bus_mar;
    assign store_commit = (state_q == ST_HI);
    assign long_instr   = (kind_q == REQ_FETCH) &&
                          ((w0_q[3:0] == I_TYPE) || (w0_q[3:0] == M_TYPE));

    // ------------------------------------------------------------------
    // Word storage
    // ------------------------------------------------------------------
`ifdef MEM_BUS_RESPONDER_UNIFIED_EN
    logic [15:0] mem [DEPTH];

    // A host write and a store commit to the same word on the same edge
    // resolve in favour of the host, because its assignment comes last.
    always_ff @(posedge clk) begin
        if (!rst && store_commit) begin
            mem[idx_q] <= {out_bus, st_lo_q};
        end
        if (prog_we) begin
            mem[prog_addr] <= prog_data;
        end
    end

    assign instr_rd  = mem[idx_full];
    assign instr_nxt = mem[idx_next];
    assign data_rd   = mem[idx_full];
    assign dbg_data  = mem[dbg_addr];
`else
    logic [15:0] instr_mem [DEPTH];
    logic [15:0] data_mem  [DEPTH];

    // The host loads program images at any time, including during reset.
    always_ff @(posedge clk) begin
        if (prog_we) begin
            instr_mem[prog_addr] <= prog_data;
        end
    end

    // NOTE: only the data array is cleared on reset; the instruction array
    // keeps its image, so it stays a plain RAM without a reset port.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_mem[i] <= '0;
            end
        end else if (store_commit) begin
            data_mem[idx_q] <= {out_bus, st_lo_q};
        end
    end

    assign instr_rd  = instr_mem[idx_full];
    assign instr_nxt = instr_mem[idx_next];
    assign data_rd   = data_mem[idx_full];
    assign dbg_data  = data_mem[dbg_addr];
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so that every
    // flop samples values from before the edge, whatever the block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: state_d gets its default before the case statement, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (halt) begin
                    state_d = HALTED;
                end else if (req_valid) begin
                    state_d = ADDR_HI;
                end
            end
            ADDR_HI: state_d = (kind_q == REQ_STORE) ? ST_LO : TX0_LO;
            TX0_LO:  state_d = TX0_HI;
            TX0_HI:  state_d = long_instr ? TX1_LO : IDLE;
            TX1_LO:  state_d = TX1_HI;
            TX1_HI:  state_d = IDLE;
            ST_LO:   state_d = ST_HI;
            ST_HI:   state_d = IDLE;
            HALTED:  state_d = HALTED;
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Request capture and word latching. W0/W1 are snapshots: host writes
    // after the ADDR_HI edge do not reach the bytes being transmitted.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            kind_q  <= REQ_FETCH;
            idx_q   <= '0;
            w0_q    <= '0;
            w1_q    <= '0;
            st_lo_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!halt && req_valid) begin
                        // A fetch request takes priority over a data access.
                        if (bus_pc) begin
                            kind_q <= REQ_FETCH;
                        end else if (bus_mdr) begin
                            kind_q <= REQ_STORE;
                        end else begin
                            kind_q <= REQ_LOAD;
                        end
                        idx_q <= AW'(out_bus);
                    end
                end
                ADDR_HI: begin
                    idx_q <= idx_full;
                    if (kind_q == REQ_FETCH) begin
                        w0_q <= instr_rd;
                        w1_q <= instr_nxt;
                    end else begin
                        w0_q <= data_rd;
                    end
                end
                ST_LO: begin
                    st_lo_q <= out_bus;
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs, decoded from state. in_bus stays at zero unless a byte is
    // being presented.
    // ------------------------------------------------------------------
    always_comb begin
        in_bus            = 8'h00;
        ard_data_ready    = 1'b0;
        ard_receive_ready = 1'b0;
        unique case (state_q)
            IDLE: begin
                ard_receive_ready = 1'b1;
            end
            TX0_LO: begin
                ard_data_ready = 1'b1;
                in_bus         = w0_q[7:0];
            end
            TX0_HI: begin
                ard_data_ready = 1'b1;
                in_bus         = w0_q[15:8];
            end
            TX1_LO: begin
                ard_data_ready = 1'b1;
                in_bus         = w1_q[7:0];
            end
            TX1_HI: begin
                ard_data_ready = 1'b1;
                in_bus         = w1_q[15:8];
            end
            ST_LO, ST_HI: begin
                ard_receive_ready = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule
